text_overlay_renderer: RTL and testbench

- Pixel-pipeline stage directly upstream of the character ROM (characterRom: 7-bit Address in, 8-bit pxInRow out; Address = {glyph code[2:0], glyph row[3:0]}; bit n of pxInRow is font column n, with bit 0 the leftmost).
- Takes raster coordinates and syncs from the VGA timing generator and places a string of NUM_CHARS glyphs at a fixed screen origin, scaled by 2^SCALE_LOG2.
- Drives the ROM address, selects the pixel bit, and emits a foreground flag with syncs delay-matched.
- Holds a double-buffered text register so that writes appear only at frame start and never tear.

---
 rtl/text_overlay_pkg.sv | 24 ++
 rtl/text_overlay_renderer_if.sv | 14 +
 rtl/text_overlay_renderer_text_buffer.sv | 65 ++++++
 rtl/text_overlay_renderer.sv | 110 +++++++++++
 tb/tb_text_overlay_renderer.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/text_overlay_pkg.sv
// Shared constants for the text overlay renderer: glyph codes, font geometry
// and the fixed pipeline depth of the renderer.
package text_overlay_pkg;

  localparam logic [2:0] GLYPH_F     = 3'd0;
  localparam logic [2:0] GLYPH_Q     = 3'd1;
  localparam logic [2:0] GLYPH_H     = 3'd2;
  localparam logic [2:0] GLYPH_X     = 3'd3;
  localparam logic [2:0] GLYPH_U     = 3'd4;
  localparam logic [2:0] GLYPH_BLANK = 3'd5;

  localparam int GLYPH_ROWS = 16;
  localparam int GLYPH_COLS = 8;

  localparam logic [6:0] BLANK_ADDR = 7'h50;

  localparam int PIPE_LATENCY = 2;

  // Codes above the last defined glyph have no font entry, so they fold onto blank.
  function automatic logic [2:0] clampGlyph(input logic [2:0] code);
    return (code > GLYPH_BLANK) ? GLYPH_BLANK : code;
  endfunction

endpackage

// File: rtl/text_overlay_renderer_if.sv
// Write bus into the shadow text buffer. The host side drives it (master),
// the renderer consumes it (slave).
interface text_overlay_renderer_if #(
  parameter int IDX_W = 3
) ();

  logic             wrEn;
  logic [IDX_W-1:0] wrIdx;
  logic [2:0]       wrCode;

  modport master (output wrEn, output wrIdx, output wrCode);
  modport slave  (input  wrEn, input  wrIdx, input  wrCode);

endinterface

// File: rtl/text_overlay_renderer_text_buffer.sv
// Double-buffered glyph store. Host writes land in the shadow copy; the shadow
// is copied to the display copy on the leading edge of vertical sync so the
// visible string never changes mid-frame.
module text_buffer
  import text_overlay_pkg::*;
#(
  parameter int NUM_CHARS       = 8,
  parameter int IDX_W           = 3,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    resetN,
  text_overlay_renderer_if.slave  wr,
  input  logic                    vSyncIn,
  input  logic [IDX_W-1:0]        readSlot,
  output logic [2:0]              readCode,
  output logic                    commitPulse
);

  localparam logic SYNC_IDLE = (SYNC_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  logic [2:0] shadow  [NUM_CHARS];
  logic [2:0] display [NUM_CHARS];
  logic       vSyncPrev;
  logic       wrHit;
  logic       commit;
  logic [2:0] wrCodeClamped;

  assign wrCodeClamped = clampGlyph(wr.wrCode);
  assign wrHit         = wr.wrEn && (int'(wr.wrIdx) < NUM_CHARS);
  assign commit        = (vSyncIn != SYNC_IDLE) && (vSyncPrev == SYNC_IDLE);

  // Shadow writes, vsync history and the commit copy; a write landing on the
  // commit edge is forwarded straight into the display copy as well.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_CHARS; i++) begin
        shadow[i]  <= GLYPH_BLANK;
        display[i] <= GLYPH_BLANK;
      end
      vSyncPrev   <= SYNC_IDLE;
      commitPulse <= 1'b0;
    end else begin
      vSyncPrev   <= vSyncIn;
      commitPulse <= commit;
      for (int i = 0; i < NUM_CHARS; i++) begin
        if (wrHit && (wr.wrIdx == IDX_W'(i))) begin
          shadow[i] <= wrCodeClamped;
        end
        if (commit) begin
          display[i] <= (wrHit && (wr.wrIdx == IDX_W'(i))) ? wrCodeClamped : shadow[i];
        end
      end
    end
  end

  // Display lookup for the renderer; slots past the string read as blank.
  always_comb begin
    readCode = GLYPH_BLANK;
    if (int'(readSlot) < NUM_CHARS) begin
      readCode = display[readSlot];
    end
  end

endmodule

// File: rtl/text_overlay_renderer.sv
// Overlays a fixed-position, integer-scaled text string on the raster. Stage 1
// turns the raster position into a character ROM address; stage 2 picks the
// font column out of the ROM row. Syncs and videoOn ride along so everything
// leaves with the same two-cycle lag.
module text_overlay_renderer
  import text_overlay_pkg::*;
#(
  parameter int NUM_CHARS       = 8,
  parameter int IDX_W           = 3,
  parameter int COORD_W         = 10,
  parameter int ORIGIN_X        = 256,
  parameter int ORIGIN_Y        = 224,
  parameter int SCALE_LOG2      = 1,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic [COORD_W-1:0]     pixelX,
  input  logic [COORD_W-1:0]     pixelY,
  input  logic                   videoOn,
  input  logic                   hSyncIn,
  input  logic                   vSyncIn,
  text_overlay_renderer_if.slave wr,
  output logic [6:0]             romAddress,
  input  logic [7:0]             romPxInRow,
  output logic                   pixelOn,
  output logic                   videoOnOut,
  output logic                   hSyncOut,
  output logic                   vSyncOut,
  output logic                   commitPulse
);

  localparam logic SYNC_IDLE = (SYNC_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam int   X_END     = ORIGIN_X + NUM_CHARS * (GLYPH_COLS << SCALE_LOG2);
  localparam int   Y_END     = ORIGIN_Y + (GLYPH_ROWS << SCALE_LOG2);

  logic [COORD_W-1:0] dx;
  logic [COORD_W-1:0] dy;
  logic [IDX_W-1:0]   slot;
  logic [2:0]         col;
  logic [3:0]         row;
  logic               inRegion;
  logic [2:0]         glyphCode;

  logic [2:0]         colD;
  logic               inRegionD;
  logic               videoOnD;
  logic               hSyncD;
  logic               vSyncD;

  assign dx   = pixelX - COORD_W'(ORIGIN_X);
  assign dy   = pixelY - COORD_W'(ORIGIN_Y);
  assign slot = IDX_W'(dx >> (3 + SCALE_LOG2));
  assign col  = 3'(dx >> SCALE_LOG2);
  assign row  = 4'(dy >> SCALE_LOG2);

  assign inRegion = (int'(pixelX) >= ORIGIN_X) && (int'(pixelX) < X_END) &&
                    (int'(pixelY) >= ORIGIN_Y) && (int'(pixelY) < Y_END);

  text_buffer #(
    .NUM_CHARS       (NUM_CHARS),
    .IDX_W           (IDX_W),
    .SYNC_ACTIVE_LOW (SYNC_ACTIVE_LOW)
  ) textBuffer (
    .clk         (clk),
    .resetN      (resetN),
    .wr          (wr),
    .vSyncIn     (vSyncIn),
    .readSlot    (slot),
    .readCode    (glyphCode),
    .commitPulse (commitPulse)
  );

  // Stage 1: register the ROM address (parked on the blank glyph outside the
  // text box) and carry column, region and timing signals forward.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      romAddress <= BLANK_ADDR;
      colD       <= 3'd0;
      inRegionD  <= 1'b0;
      videoOnD   <= 1'b0;
      hSyncD     <= SYNC_IDLE;
      vSyncD     <= SYNC_IDLE;
    end else begin
      romAddress <= inRegion ? {glyphCode, row} : BLANK_ADDR;
      colD       <= col;
      inRegionD  <= inRegion;
      videoOnD   <= videoOn;
      hSyncD     <= hSyncIn;
      vSyncD     <= vSyncIn;
    end
  end

  // Stage 2: select the font column from the ROM row and emit it with the
  // second delay of the timing signals.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      pixelOn    <= 1'b0;
      videoOnOut <= 1'b0;
      hSyncOut   <= SYNC_IDLE;
      vSyncOut   <= SYNC_IDLE;
    end else begin
      pixelOn    <= inRegionD & videoOnD & romPxInRow[colD];
      videoOnOut <= videoOnD;
      hSyncOut   <= hSyncD;
      vSyncOut   <= vSyncD;
    end
  end

endmodule

// File: tb/tb_text_overlay_renderer.sv
// Bench for text_overlay_renderer: a behavioural font ROM feeds the DUT, and a
// reference model built from the geometry and buffering rules predicts every
// output each cycle under directed and random stimulus.
module tb_text_overlay_renderer;

  localparam int NC = 8;
  localparam int SC = 2;
  localparam int OX = 256;
  localparam int OY = 224;

  typedef struct {
    logic [6:0] addr;
    logic       pix;
    logic       vid;
    logic       hs;
    logic       vs;
  } stage_t;

  logic       clk = 1'b0;
  logic       resetN;
  logic [9:0] pixelX;
  logic [9:0] pixelY;
  logic       videoOn;
  logic       hSyncIn;
  logic       vSyncIn;
  logic [6:0] romAddress;
  logic [7:0] romPxInRow;
  logic       pixelOn;
  logic       videoOnOut;
  logic       hSyncOut;
  logic       vSyncOut;
  logic       commitPulse;

  int checkCount = 0;
  int failCount  = 0;

  int     mShadow  [NC];
  int     mDisplay [NC];
  logic   mVsPrev;
  logic   mPulse;
  stage_t m1;
  stage_t m2;

  text_overlay_renderer_if #(.IDX_W(3)) wrBus ();

  text_overlay_renderer dut (
    .clk         (clk),
    .resetN      (resetN),
    .pixelX      (pixelX),
    .pixelY      (pixelY),
    .videoOn     (videoOn),
    .hSyncIn     (hSyncIn),
    .vSyncIn     (vSyncIn),
    .wr          (wrBus.slave),
    .romAddress  (romAddress),
    .romPxInRow  (romPxInRow),
    .pixelOn     (pixelOn),
    .videoOnOut  (videoOnOut),
    .hSyncOut    (hSyncOut),
    .vSyncOut    (vSyncOut),
    .commitPulse (commitPulse)
  );

  always #5 clk = ~clk;

  // Font rows per glyph; bit n is font column n, bit 0 leftmost.
  function automatic logic [7:0] fontRow(input int code, input int row);
    case (code)
      0: return (row < 2) ? 8'hFF : ((row == 7 || row == 8) ? 8'h3F : 8'h03);
      1: return (row == 0 || row == 15) ? 8'h7E : 8'hC3;
      2: return (row == 7 || row == 8) ? 8'hFF : 8'hC3;
      3: return 8'(8'h01 << (row / 2)) | 8'(8'h80 >> (row / 2));
      4: return (row == 15) ? 8'h7E : 8'hC3;
      default: return 8'h00;
    endcase
  endfunction

  // Character ROM stand-in, combinational like the real part.
  always_comb romPxInRow = fontRow(int'(romAddress[6:4]), int'(romAddress[3:0]));

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Reference model: advance one clock edge using the current inputs.
  task automatic modelStep();
    stage_t n;
    stage_t rst;
    int x, y, slot, col, row, glyph;
    logic inR, commit;
    logic [7:0] fr;
    rst.addr = 7'h50; rst.pix = 1'b0; rst.vid = 1'b0; rst.hs = 1'b1; rst.vs = 1'b1;
    if (!resetN) begin
      m1 = rst;
      m2 = rst;
      mPulse = 1'b0;
      mVsPrev = 1'b1;
      for (int i = 0; i < NC; i++) begin
        mShadow[i] = 5;
        mDisplay[i] = 5;
      end
      return;
    end
    x = int'(pixelX);
    y = int'(pixelY);
    inR = (x >= OX) && (x < OX + NC * 8 * SC) && (y >= OY) && (y < OY + 16 * SC);
    n.addr = 7'h50;
    n.pix = 1'b0;
    if (inR) begin
      slot = (x - OX) / (8 * SC);
      col = ((x - OX) / SC) % 8;
      row = ((y - OY) / SC) % 16;
      glyph = mDisplay[slot];
      fr = fontRow(glyph, row);
      n.addr = 7'(glyph * 16 + row);
      n.pix = videoOn & fr[col];
    end
    n.vid = videoOn;
    n.hs = hSyncIn;
    n.vs = vSyncIn;
    m2 = m1;
    m1 = n;
    commit = (vSyncIn == 1'b0) && (mVsPrev == 1'b1);
    mVsPrev = vSyncIn;
    mPulse = commit;
    if (wrBus.wrEn && int'(wrBus.wrIdx) < NC) begin
      mShadow[wrBus.wrIdx] = (wrBus.wrCode > 3'd5) ? 5 : int'(wrBus.wrCode);
    end
    if (commit) begin
      for (int i = 0; i < NC; i++) mDisplay[i] = mShadow[i];
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare every output to the model.
  task automatic applyStimulus(input int x, input int y, input logic vid, input logic hs,
                               input logic vs, input logic we, input int idx, input int code,
                               input logic rstN);
    pixelX = 10'(x);
    pixelY = 10'(y);
    videoOn = vid;
    hSyncIn = hs;
    vSyncIn = vs;
    wrBus.wrEn = we;
    wrBus.wrIdx = 3'(idx);
    wrBus.wrCode = 3'(code);
    resetN = rstN;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput("romAddress", 32'(romAddress), 32'(m1.addr));
    checkOutput("pixelOn", 32'(pixelOn), 32'(m2.pix));
    checkOutput("videoOnOut", 32'(videoOnOut), 32'(m2.vid));
    checkOutput("hSyncOut", 32'(hSyncOut), 32'(m2.hs));
    checkOutput("vSyncOut", 32'(vSyncOut), 32'(m2.vs));
    checkOutput("commitPulse", 32'(commitPulse), 32'(mPulse));
  endtask

  task automatic idle(input int x, input int y);
    applyStimulus(x, y, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 1'b1);
  endtask

  task automatic writeSlot(input int idx, input int code);
    applyStimulus(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, idx, code, 1'b1);
  endtask

  task automatic vsyncPulse();
    applyStimulus(0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1);
    checkOutput("commitSeen", 32'(commitPulse), 32'd1);
    idle(0, 0);
    checkOutput("commitOneCycle", 32'(commitPulse), 32'd0);
  endtask

  // Present one raster point, then check the pixel produced two edges later.
  task automatic pointCheck(input string tag, input int x, input int y, input logic vid,
                            input logic expPix);
    applyStimulus(x, y, vid, 1'b1, 1'b1, 1'b0, 0, 0, 1'b1);
    idle(0, 0);
    checkOutput(tag, 32'(pixelOn), 32'(expPix));
  endtask

  initial begin
    wrBus.wrEn = 1'b0;
    wrBus.wrIdx = 3'd0;
    wrBus.wrCode = 3'd0;

    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
    checkOutput("resetAddr", 32'(romAddress), 32'h50);
    checkOutput("resetPix", 32'(pixelOn), 32'd0);
    checkOutput("resetHsync", 32'(hSyncOut), 32'd1);

    $display("[TB] idle sweep over blank text region");
    for (int y = 220; y < 262; y += 2) begin
      for (int x = 250; x < 392; x += 3) begin
        idle(x, y);
        if (x >= OX + 1 && x < OX + NC * 16 && y >= OY + 1 && y < OY + 32) begin
          checkOutput("blankAddrRange", 32'(romAddress[6:4]), 32'd5);
        end
      end
    end

    $display("[TB] slot0 = F, commit");
    writeSlot(0, 0);
    vsyncPulse();
    idle(256, 224);
    checkOutput("fOriginAddr", 32'(romAddress), 32'h00);
    idle(0, 0);
    checkOutput("fOriginPix", 32'(pixelOn), 32'd1);
    pointCheck("fCol1Row2", 259, 228, 1'b1, 1'b1);
    pointCheck("fCol3Row2", 262, 228, 1'b1, 1'b0);

    $display("[TB] slot7 = H boundaries");
    writeSlot(7, 2);
    vsyncPulse();
    pointCheck("leftEdge255", 255, 224, 1'b1, 1'b0);
    pointCheck("rightEdge383", 383, 224, 1'b1, 1'b1);
    pointCheck("pastRight384", 384, 224, 1'b1, 1'b0);
    pointCheck("belowBottom256", 300, 256, 1'b1, 1'b0);
    pointCheck("videoOff", 256, 224, 1'b0, 1'b0);

    $display("[TB] tear-free and bypass");
    writeSlot(1, 3);
    pointCheck("noTear", 272, 224, 1'b1, 1'b0);
    applyStimulus(0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 2, 4, 1'b1);
    checkOutput("bypassCommit", 32'(commitPulse), 32'd1);
    idle(0, 0);
    pointCheck("bypassSlot2", 288, 224, 1'b1, 1'b1);
    pointCheck("slot1AfterCommit", 272, 224, 1'b1, 1'b1);

    $display("[TB] code clamp");
    writeSlot(0, 7);
    vsyncPulse();
    pointCheck("clampBlank", 256, 224, 1'b1, 1'b0);

    $display("[TB] mid-line reset");
    idle(383, 224);
    applyStimulus(383, 224, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    checkOutput("midResetAddr", 32'(romAddress), 32'h50);
    checkOutput("midResetPix", 32'(pixelOn), 32'd0);
    checkOutput("midResetVsync", 32'(vSyncOut), 32'd1);
    idle(383, 224);
    checkOutput("flushPix", 32'(pixelOn), 32'd0);
    pointCheck("slotsBlank", 383, 224, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(300, 230, 1'b1, 1'(i % 3 != 0), 1'b1, 1'b0, 0, 0, 1'b1);
    end

    $display("[TB] random traffic");
    for (int i = 0; i < 4000; i++) begin
      applyStimulus(int'($urandom_range(400, 240)), int'($urandom_range(270, 210)),
                    1'($urandom_range(9, 0) != 0), 1'($urandom_range(1, 0)),
                    1'($urandom_range(15, 0) != 0), 1'($urandom_range(3, 0) == 0),
                    int'($urandom_range(7, 0)), int'($urandom_range(7, 0)),
                    1'($urandom_range(299, 0) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
